// File: rtl/mantissa_multiplier.sv
// rtl/mantissa_multiplier.sv - pipelined unsigned NxN mantissa multiplier (CSA tree + final adder)
// Optional MULT_PIPE2_EN: registers the sum/carry rows ahead of the final adder (latency 2).
module mantissa_multiplier #(
    parameter int N = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             out_valid,
    output logic [2*N-1:0]   result
);

    localparam int W = 2 * N;

    // Rows left after one level of 3:2 compression on r rows.
    function automatic int reduce_once(input int r);
        return 2 * (r / 3) + (r % 3);
    endfunction

    function automatic int rows_at(input int lvl);
        int r;
        r = N;
        for (int i = 0; i < lvl; i++) begin
            if (r > 2) r = reduce_once(r);
        end
        return r;
    endfunction

    function automatic int num_levels();
        int r;
        int l;
        r = N;
        l = 0;
        while (r > 2) begin
            r = reduce_once(r);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels();

    // tree[l][j]: row j after l compression levels; rows beyond the live count are tied to zero.
    logic [W-1:0] tree [0:LEVELS][0:N-1];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pp
            assign tree[0][gi] = ({{N{1'b0}}, A} << gi) & {W{B[gi]}};
        end
    endgenerate

    genvar gl, gg, gp, gz;
    generate
        for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
            localparam int R      = rows_at(gl);
            localparam int G      = R / 3;
            localparam int R_NEXT = rows_at(gl + 1);

            for (gg = 0; gg < G; gg++) begin : g_csa
                logic [W-1:0] x;
                logic [W-1:0] y;
                logic [W-1:0] z;
                logic [W-2:0] maj;
                assign x   = tree[gl][3*gg];
                assign y   = tree[gl][3*gg+1];
                assign z   = tree[gl][3*gg+2];
                assign maj = (x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]);
                assign tree[gl+1][2*gg]   = x ^ y ^ z;
                // Carry out of the top bit is always zero because the true product fits in W bits.
                assign tree[gl+1][2*gg+1] = {maj, 1'b0};
            end

            for (gp = 0; gp < R % 3; gp++) begin : g_pass
                assign tree[gl+1][2*G+gp] = tree[gl][3*G+gp];
            end

            for (gz = R_NEXT; gz < N; gz++) begin : g_zero
                assign tree[gl+1][gz] = '0;
            end
        end
    endgenerate

    logic [W-1:0] sum_row;
    logic [W-1:0] carry_row;

    assign sum_row   = tree[LEVELS][0];
    assign carry_row = tree[LEVELS][1];

`ifdef MULT_PIPE2_EN
    logic [W-1:0] sum_q;
    logic [W-1:0] carry_q;
    logic         valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            carry_q   <= '0;
            valid_q   <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            valid_q   <= in_valid;
            out_valid <= valid_q;
            if (in_valid) begin
                sum_q   <= sum_row;
                carry_q <= carry_row;
            end
            if (valid_q) begin
                result <= sum_q + carry_q;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= sum_row + carry_row;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mantissa_multiplier.sv
// tb/tb_mantissa_multiplier.sv - directed and streaming checks for mantissa_multiplier
module tb_mantissa_multiplier;

    localparam int N = 11;
    localparam int W = 2 * N;
`ifdef MULT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic [W-1:0] result;

    mantissa_multiplier #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] p;
    } vec_t;

    vec_t vecs [8];

    int pass_cnt;
    int total_cnt;
    int vcount;

    logic         pv [LAT];
    logic [W-1:0] pd [LAT];
    logic [W-1:0] exp_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock: drive inputs, advance the reference pipeline, compare outputs.
    task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic r);
        in_valid = v;
        A        = a;
        B        = b;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < LAT; k++) pv[k] = 1'b0;
            exp_res = '0;
        end else begin
            for (int k = LAT - 1; k > 0; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[0] = v;
            pd[0] = {{N{1'b0}}, a} * {{N{1'b0}}, b};
            if (pv[LAT-1]) exp_res = pd[LAT-1];
        end
        if (out_valid === 1'b1) vcount++;
        chk("cycle_valid", {63'd0, out_valid}, {63'd0, pv[LAT-1]});
        chk("cycle_result", {42'd0, result}, {42'd0, exp_res});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, N'($urandom), N'($urandom), 1'b0);
    endtask

    initial begin
        int nv;
        logic v;

        pass_cnt  = 0;
        total_cnt = 0;
        vcount    = 0;
        exp_res   = '0;
        for (int k = 0; k < LAT; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;

        vecs[0] = '{"unity",      11'h400, 11'h400, 22'h100000};
        vecs[1] = '{"mixed",      11'h400, 11'h600, 22'h180000};
        vecs[2] = '{"max",        11'h7FF, 11'h7FF, 22'h3FF001};
        vecs[3] = '{"zero_a",     11'h000, 11'h7FF, 22'h000000};
        vecs[4] = '{"one_a",      11'h001, 11'h5A3, 22'h0005A3};
        vecs[5] = '{"one_b",      11'h7FF, 11'h001, 22'h0007FF};
        vecs[6] = '{"alt_x3",     11'h555, 11'h003, 22'h000FFF};
        vecs[7] = '{"max_x_unit", 11'h7FF, 11'h400, 22'h1FFC00};

        // Reset with a live operand on the inputs
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 11'd5, 11'd7, 1'b1);
            chk("reset_valid", {63'd0, out_valid}, 64'd0);
            chk("reset_result", {42'd0, result}, 64'd0);
        end
        step(1'b0, 11'd5, 11'd7, 1'b0);
        chk("post_reset_valid", {63'd0, out_valid}, 64'd0);
        chk("post_reset_result", {42'd0, result}, 64'd0);

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b, 1'b0);
            idle(LAT - 1);
            chk({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
            chk(vecs[i].name, {42'd0, result}, {42'd0, vecs[i].p});
            idle(1);
            chk({vecs[i].name, "_pulse_end"}, {63'd0, out_valid}, 64'd0);
            chk({vecs[i].name, "_hold"}, {42'd0, result}, {42'd0, vecs[i].p});
        end

        // Back-to-back stream
        vcount = 0;
        for (int k = 0; k < 100; k++) step(1'b1, N'($urandom), N'($urandom), 1'b0);
        idle(LAT);
        chk("stream_count", 64'(vcount), 64'd100);

        // Stream with gaps; operands randomised while invalid
        vcount = 0;
        nv     = 0;
        for (int k = 0; k < 100; k++) begin
            v = 1'($urandom);
            if (v) nv++;
            step(v, N'($urandom), N'($urandom), 1'b0);
        end
        idle(LAT);
        chk("gap_count", 64'(vcount), 64'(nv));

        // Reset right behind an issued operation
        step(1'b1, 11'd3, 11'd4, 1'b0);
        step(1'b0, 11'd0, 11'd0, 1'b1);
        chk("midreset_valid", {63'd0, out_valid}, 64'd0);
        chk("midreset_result", {42'd0, result}, 64'd0);
        vcount = 0;
        idle(LAT);
        chk("midreset_no_pulse", 64'(vcount), 64'd0);
        step(1'b1, 11'd9, 11'd9, 1'b0);
        idle(LAT - 1);
        chk("after_reset_valid", {63'd0, out_valid}, 64'd1);
        chk("after_reset_result", {42'd0, result}, 64'd81);
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
